// File: rtl/duc_rate_ctrl.sv
// Reconfiguration sequencer for the 3-stage half-band DUC: gates the input handshake, drains in-flight samples, swaps bypass.
// Optional DRAIN timeout via `define DUC_CTRL_TIMEOUT_EN; gate is combinational (zero latency), input closed whenever not RUN or full.
module duc_rate_ctrl #(
   parameter logic [2:0] BYPASS_RST      = 3'b000,
   parameter int         MAX_OUTSTANDING = 64,
   parameter int         CNT_WIDTH       = 8,
   parameter int         SETTLE_CYCLES   = 4,
   parameter int         TIMEOUT_CYCLES  = 1024
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic [2:0]           cfg_bypass_in,
   input  logic                 cfg_valid_in,
   output logic                 cfg_ready_out,
   input  logic                 up_valid_in,
   output logic                 up_ready_out,
   output logic                 duc_valid_out,
   input  logic                 duc_ready_in,
   input  logic                 mon_valid_in,
   input  logic                 mon_ready_in,
   output logic [2:0]           bypass_out,
   output logic                 flush_out,
   output logic                 busy_out,
   output logic [CNT_WIDTH-1:0] outstanding_out,
   output logic                 timeout_err_out
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_APPLY, ST_SETTLE} state_t;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_WIDTH:0] MAX_W = (CNT_WIDTH+1)'(MAX_OUTSTANDING);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] outstanding, cnt_nxt;
   logic [2:0]           pending;
   logic [SW-1:0]        settle_cnt;
   logic [1:0]           zeros;
   logic [CNT_WIDTH-1:0] inc;
   logic [CNT_WIDTH:0]   sum_w;
   logic                 gate_open, in_fire, out_fire, cfg_fire, tmo_hit;

   // Each active (zero) bypass bit doubles the output samples per input.
   assign zeros = {1'b0, ~bypass_out[0]} + {1'b0, ~bypass_out[1]} + {1'b0, ~bypass_out[2]};
   assign inc   = CNT_WIDTH'(1) << zeros;
   assign sum_w = {1'b0, outstanding} + {1'b0, inc};

   assign gate_open     = (state == ST_RUN) && (sum_w <= MAX_W);
   assign up_ready_out  = duc_ready_in & gate_open;
   assign duc_valid_out = up_valid_in & gate_open;
   assign in_fire       = up_valid_in & up_ready_out;
   assign out_fire      = mon_valid_in & mon_ready_in & (outstanding != '0);
   assign cfg_ready_out = (state == ST_RUN);
   assign cfg_fire      = cfg_valid_in & cfg_ready_out;

   assign flush_out       = (state == ST_APPLY);
   assign busy_out        = (state != ST_RUN);
   assign outstanding_out = outstanding;

   always_comb begin
      cnt_nxt = outstanding;
      if (in_fire)
         cnt_nxt = cnt_nxt + inc;
      if (out_fire)
         cnt_nxt = cnt_nxt - CNT_WIDTH'(1);
   end

`ifdef DUC_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_err;

   assign tmo_hit = (state == ST_DRAIN) && (outstanding != '0) &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout_err_out = tmo_err;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (state == ST_DRAIN && !tmo_hit)
            tmo_cnt <= tmo_cnt + TW'(1);
         else
            tmo_cnt <= '0;
         if (tmo_hit)
            tmo_err <= 1'b1;
      end
   end
`else
   assign tmo_hit         = 1'b0;
   assign timeout_err_out = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:    if (cfg_fire) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (outstanding == '0 || tmo_hit) state_nxt = ST_APPLY;
         ST_APPLY:  state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = ST_RUN;
         default:   state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         outstanding <= '0;
         pending     <= BYPASS_RST;
         bypass_out  <= BYPASS_RST;
         settle_cnt  <= '0;
      end else begin
         // A timeout abandons whatever is still in flight.
         outstanding <= tmo_hit ? '0 : cnt_nxt;
         if (cfg_fire)
            pending <= cfg_bypass_in;
         if (state == ST_DRAIN && state_nxt == ST_APPLY)
            bypass_out <= pending;
         if (state == ST_SETTLE)
            settle_cnt <= settle_cnt + SW'(1);
         else
            settle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_duc_rate_ctrl.sv
// Bench for duc_rate_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_duc_rate_ctrl;
   localparam int MAXO   = 64;
   localparam int SETTLE = 4;
   localparam int TMO    = 1024;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic [2:0] cfg_bypass_in = 3'b000;
   logic       cfg_valid_in = 1'b0;
   logic       cfg_ready_out;
   logic       up_valid_in = 1'b0;
   logic       up_ready_out;
   logic       duc_valid_out;
   logic       duc_ready_in = 1'b0;
   logic       mon_valid_in = 1'b0;
   logic       mon_ready_in = 1'b0;
   logic [2:0] bypass_out;
   logic       flush_out;
   logic       busy_out;
   logic [7:0] outstanding_out;
   logic       timeout_err_out;

   always #5 clk = ~clk;

   duc_rate_ctrl dut (
      .clk(clk), .arst_n(arst_n),
      .cfg_bypass_in(cfg_bypass_in), .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
      .up_valid_in(up_valid_in), .up_ready_out(up_ready_out),
      .duc_valid_out(duc_valid_out), .duc_ready_in(duc_ready_in),
      .mon_valid_in(mon_valid_in), .mon_ready_in(mon_ready_in),
      .bypass_out(bypass_out), .flush_out(flush_out), .busy_out(busy_out),
      .outstanding_out(outstanding_out), .timeout_err_out(timeout_err_out)
   );

   int checks = 0;
   int errors = 0;

   // Model: phases of a reconfiguration as seen from outside.
   localparam int RUNNING = 0, WAITING = 1, SWAPPING = 2, HOLDING = 3;
   int m_out, m_byp, m_pend, m_phase, m_hold_left, m_wait;
   int m_err;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int samples_per_input(input int byp);
      int n = 0;
      for (int i = 0; i < 3; i++)
         if (((byp >> i) & 1) == 0) n++;
      return 1 << n;
   endfunction

   task automatic model_reset();
      m_out = 0; m_byp = 0; m_pend = 0; m_phase = RUNNING;
      m_hold_left = 0; m_wait = 0; m_err = 0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      arst_n = 1'b0;
      up_valid_in = 0; duc_ready_in = 0; mon_valid_in = 0; mon_ready_in = 0; cfg_valid_in = 0;
      repeat (n) @(posedge clk);
      #1;
      model_reset();
      chk("rst_bypass", bypass_out, 0);
      chk("rst_outstanding", outstanding_out, 0);
      chk("rst_cfg_ready", cfg_ready_out, 1);
      chk("rst_busy", busy_out, 0);
      chk("rst_flush", flush_out, 0);
      chk("rst_err", timeout_err_out, 0);
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   // One clock cycle: drive, compare combinational/registered outputs to the model, advance.
   task automatic step(input bit uv, input bit dr, input bit mv, input bit mr, input bit cv, input int cb);
      int inc, n_out, n_phase, n_byp, n_pend, n_hold, n_wait, n_err;
      bit open, in_f, out_f;
      @(negedge clk);
      up_valid_in = uv; duc_ready_in = dr; mon_valid_in = mv; mon_ready_in = mr;
      cfg_valid_in = cv; cfg_bypass_in = 3'(cb);
      #1;
      inc  = samples_per_input(m_byp);
      open = (m_phase == RUNNING) && (m_out + inc <= MAXO);
      chk("up_ready", up_ready_out, int'(dr && open));
      chk("duc_valid", duc_valid_out, int'(uv && open));
      chk("cfg_ready", cfg_ready_out, int'(m_phase == RUNNING));
      chk("busy", busy_out, int'(m_phase != RUNNING));
      chk("flush", flush_out, int'(m_phase == SWAPPING));
      chk("bypass", bypass_out, m_byp);
      chk("outstanding", outstanding_out, m_out);
      chk("timeout_err", timeout_err_out, m_err);

      in_f  = uv && dr && open;
      out_f = mv && mr && (m_out > 0);
      n_out = m_out + (in_f ? inc : 0) - (out_f ? 1 : 0);
      n_phase = m_phase; n_byp = m_byp; n_pend = m_pend; n_hold = m_hold_left;
      n_wait = 0; n_err = m_err;
      case (m_phase)
         RUNNING: if (cv) begin n_phase = WAITING; n_pend = cb; end
         WAITING: begin
            n_wait = m_wait + 1;
            if (m_out == 0) begin
               n_phase = SWAPPING; n_byp = m_pend;
            end
`ifdef DUC_CTRL_TIMEOUT_EN
            else if (n_wait == TMO) begin
               n_phase = SWAPPING; n_byp = m_pend; n_err = 1; n_out = 0;
            end
`endif
         end
         SWAPPING: begin n_phase = HOLDING; n_hold = SETTLE; end
         default: begin
            if (m_hold_left == 1) n_phase = RUNNING;
            else n_hold = m_hold_left - 1;
         end
      endcase
      @(posedge clk);
      m_out = n_out; m_phase = n_phase; m_byp = n_byp; m_pend = n_pend;
      m_hold_left = n_hold; m_wait = n_wait; m_err = n_err;
      #1;
   endtask

   initial begin
      model_reset();
      do_reset(2);

      // Two inputs with all stages active -> 16 outputs in flight.
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      chk("two_inputs_16", outstanding_out, 16);
      repeat (16) step(0, 1, 1, 1, 0, 0);
      chk("drained_16", outstanding_out, 0);

      // Simultaneous in/out fire nets both.
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      chk("net_fire_15", outstanding_out, 15);
      repeat (15) step(0, 1, 1, 1, 0, 0);

      // Fill towards the limit, then watch the gate reopen at 56.
      repeat (8) step(1, 1, 0, 0, 0, 0);
      chk("filled_64", outstanding_out, 64);
      repeat (4) step(1, 1, 1, 1, 0, 0);
      chk("at_60", outstanding_out, 60);
      chk("gate_closed_60", up_ready_out, 0);
      for (int i = 0; i < 8 && outstanding_out != 56; i++) step(0, 1, 1, 1, 0, 0);
      chk("at_56", outstanding_out, 56);
      chk("gate_open_56", up_ready_out, 1);
      for (int i = 0; i < 100 && outstanding_out != 0; i++) step(0, 1, 1, 1, 0, 0);
      chk("drained_56", outstanding_out, 0);

      // Reconfigure to 101 with 5 samples in flight.
      step(1, 1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 1, 1, 0, 0);
      chk("at_5", outstanding_out, 5);
      step(0, 1, 0, 0, 1, 5);
      chk("drain_gate", up_ready_out, 0);
      chk("drain_busy", busy_out, 1);
      repeat (5) step(0, 1, 1, 1, 0, 0);
      chk("drain_zero", outstanding_out, 0);
      chk("no_early_flush", flush_out, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("apply_flush", flush_out, 1);
      chk("apply_bypass", bypass_out, 5);
      step(0, 1, 0, 0, 0, 0);
      chk("flush_one_cycle", flush_out, 0);
      repeat (3) begin
         step(0, 1, 0, 0, 0, 0);
         chk("settle_busy", busy_out, 1);
      end
      step(0, 1, 0, 0, 0, 0);
      chk("settle_done", cfg_ready_out, 1);
      step(1, 1, 0, 0, 0, 0);
      chk("inc_two", outstanding_out, 2);

      // Stuck drain: 3 in flight, no output handshakes.
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0);
      chk("at_3", outstanding_out, 3);
      step(0, 1, 0, 0, 1, 6);
      repeat (1100) step(0, 1, 0, 0, 0, 0);
`ifdef DUC_CTRL_TIMEOUT_EN
      chk("timeout_flag", timeout_err_out, 1);
      chk("timeout_bypass", bypass_out, 6);
      chk("timeout_cleared", outstanding_out, 0);
`else
      chk("stuck_busy", busy_out, 1);
      chk("stuck_count", outstanding_out, 3);
      chk("no_timeout", timeout_err_out, 0);
`endif
      do_reset(2);

      // Random traffic with occasional reconfiguration requests.
      for (int i = 0; i < 3000; i++)
         step($urandom % 4 != 0, $urandom % 4 != 0, 1'($urandom % 2), $urandom % 4 != 0,
              $urandom % 25 == 0, int'($urandom % 8));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
